demux4to1_dispatch: RTL and testbench

Sequential dispatcher that steers a single valid/ready word stream to one of four destination channels by driving the 2-bit select of the 1-to-4 demux slices. It sits in front of the demux datapath. It holds each word in an output register until the chosen destination accepts it. Destination choice is either round-robin with a configurable burst length or directed per word, with per-channel enable masking.

---
 rtl/demux4to1_dispatch.sv | 143 ++++++++++++++
 tb/tb_demux4to1_dispatch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux4to1_dispatch.sv
// Dispatcher that steers a valid/ready word stream to one of four demux destinations,
// holding each word in an output register until the chosen destination accepts it.
module demux4to1_dispatch #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             mode,
    input  logic [3:0]       dest_en,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             err_drop,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int CNT_W = (BURST_LEN < 1) ? 1 : $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       valid_q, valid_d;
    logic             err_q, err_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             accept_s;
    logic             drop_s;
    logic             load_s;
    logic             transfer_s;
    logic [1:0]       dest_s;
    logic [CNT_W-1:0] cnt_next_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] vec;
        vec      = 4'b0000;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // First enabled destination at or after ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] en);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && en[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign in_ready  = rst_n & (|dest_en) & ((state_q == IDLE) | out_ready[sel_q]);
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err_drop  = err_q;
    assign busy      = (state_q == HOLD);

    // Accept/transfer decode and next-state computation for datapath and round-robin pointer.
    always_comb begin
        accept_s    = in_valid & in_ready;
        transfer_s  = (state_q == HOLD) & out_ready[sel_q];
        dest_s      = mode ? in_dest : rr_pick(rr_ptr_q, dest_en);
        drop_s      = accept_s & mode & ~dest_en[in_dest];
        load_s      = accept_s & ~drop_s;
        cnt_next_s  = (dest_s != rr_ptr_q) ? CNT_W'(1) : (burst_cnt_q + CNT_W'(1));

        state_d     = state_q;
        sel_d       = sel_q;
        data_d      = data_q;
        valid_d     = valid_q;
        err_d       = drop_s;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        if (load_s) begin
            state_d = HOLD;
            sel_d   = dest_s;
            data_d  = in_data;
            valid_d = onehot4(dest_s);
        end else if (transfer_s) begin
            state_d = IDLE;
            valid_d = 4'b0000;
        end else begin
            state_d = state_q;
        end

        if (load_s && !mode) begin
            if (cnt_next_s == BURST_MAX) begin
                rr_ptr_d    = dest_s + 2'd1;
                burst_cnt_d = '0;
            end else begin
                rr_ptr_d    = dest_s;
                burst_cnt_d = cnt_next_s;
            end
        end else begin
            rr_ptr_d    = rr_ptr_q;
            burst_cnt_d = burst_cnt_q;
        end
    end

    // State and output registers; reset drops any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            data_q      <= '0;
            valid_q     <= 4'b0000;
            err_q       <= 1'b0;
            rr_ptr_q    <= 2'd0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_demux4to1_dispatch.sv
// Directed-vector bench for demux4to1_dispatch with hand-computed expectations.
module tb_demux4to1_dispatch;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       mode;
    logic [3:0] dest_en;
    logic [1:0] sel;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       err_drop;
    logic       busy;

    int checks = 0;
    int passed = 0;

    demux4to1_dispatch #(.WIDTH(8), .BURST_LEN(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .dest_en   (dest_en),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_drop  (err_drop),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_dest = 2'd0;
        mode = 1'b0; dest_en = 4'b1111; out_ready = 4'b1111;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (sel !== 2'd0) $display("FAIL reset_sel got %0h exp 0", sel); else passed++;
        checks++; if (out_data !== 8'h00) $display("FAIL reset_data got %0h exp 00", out_data); else passed++;
        checks++; if (out_valid !== 4'b0000) $display("FAIL reset_valid got %b exp 0000", out_valid); else passed++;
        checks++; if (err_drop !== 1'b0) $display("FAIL reset_err got %b exp 0", err_drop); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) $display("FAIL reset_hold_valid got %b exp 0000", out_valid); else passed++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_rr_burst();
        logic [7:0] d  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [1:0] es [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        logic [3:0] ev [6] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        mode = 1'b0; dest_en = 4'b1111; out_ready = 4'b1111;
        checks++; if (out_valid !== 4'b0000) $display("FAIL rr_pre_valid got %b exp 0000", out_valid); else passed++;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = d[i];
            #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL rr_in_ready[%0d] got %b exp 1", i, in_ready); else passed++;
            @(posedge clk); #1;
            checks++; if (sel !== es[i]) $display("FAIL rr_sel[%0d] got %0d exp %0d", i, sel, es[i]); else passed++;
            checks++; if (out_valid !== ev[i]) $display("FAIL rr_valid[%0d] got %b exp %b", i, out_valid, ev[i]); else passed++;
            checks++; if (out_data !== d[i]) $display("FAIL rr_data[%0d] got %h exp %h", i, out_data, d[i]); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL rr_busy[%0d] got %b exp 1", i, busy); else passed++;
        end
    endtask

    task automatic test_rr_skip();
        logic [7:0] d  [3] = '{8'h77, 8'h88, 8'h99};
        logic [1:0] es [3] = '{2'd3, 2'd3, 2'd0};
        logic [3:0] ev [3] = '{4'b1000, 4'b1000, 4'b0001};
        dest_en = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = d[i];
            @(posedge clk); #1;
            checks++; if (sel !== es[i]) $display("FAIL skip_sel[%0d] got %0d exp %0d", i, sel, es[i]); else passed++;
            checks++; if (out_valid !== ev[i]) $display("FAIL skip_valid[%0d] got %b exp %b", i, out_valid, ev[i]); else passed++;
            checks++; if (out_data !== d[i]) $display("FAIL skip_data[%0d] got %h exp %h", i, out_data, d[i]); else passed++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) $display("FAIL skip_drain_valid got %b exp 0000", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL skip_drain_busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_directed();
        mode = 1'b1; dest_en = 4'b1011; out_ready = 4'b1111;
        in_valid = 1'b1; in_dest = 2'd2; in_data = 8'hA5;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL dir_ready_pre got %b exp 1", in_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (err_drop !== 1'b1) $display("FAIL dir_err got %b exp 1", err_drop); else passed++;
        checks++; if (out_valid !== 4'b0000) $display("FAIL dir_drop_valid got %b exp 0000", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL dir_drop_busy got %b exp 0", busy); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL dir_ready_post got %b exp 1", in_ready); else passed++;
        in_dest = 2'd1; in_data = 8'h5A;
        @(posedge clk); #1;
        checks++; if (err_drop !== 1'b0) $display("FAIL dir_err_clear got %b exp 0", err_drop); else passed++;
        checks++; if (out_valid !== 4'b0010) $display("FAIL dir_valid got %b exp 0010", out_valid); else passed++;
        checks++; if (out_data !== 8'h5A) $display("FAIL dir_data got %h exp 5a", out_data); else passed++;
        checks++; if (sel !== 2'd1) $display("FAIL dir_sel got %0d exp 1", sel); else passed++;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) $display("FAIL dir_drain got %b exp 0000", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        mode = 1'b1; dest_en = 4'b1111; out_ready = 4'b1101;
        in_valid = 1'b1; in_dest = 2'd1; in_data = 8'h3C;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0010) $display("FAIL bp_first_valid got %b exp 0010", out_valid); else passed++;
        in_dest = 2'd3; in_data = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); else passed++;
            @(posedge clk); #1;
            checks++; if (sel !== 2'd1) $display("FAIL bp_sel[%0d] got %0d exp 1", i, sel); else passed++;
            checks++; if (out_data !== 8'h3C) $display("FAIL bp_data[%0d] got %h exp 3c", i, out_data); else passed++;
            checks++; if (out_valid !== 4'b0010) $display("FAIL bp_valid[%0d] got %b exp 0010", i, out_valid); else passed++;
        end
        out_ready = 4'b1111;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", in_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (sel !== 2'd3) $display("FAIL bp_next_sel got %0d exp 3", sel); else passed++;
        checks++; if (out_data !== 8'hC3) $display("FAIL bp_next_data got %h exp c3", out_data); else passed++;
        checks++; if (out_valid !== 4'b1000) $display("FAIL bp_next_valid got %b exp 1000", out_valid); else passed++;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) $display("FAIL bp_drain got %b exp 0000", out_valid); else passed++;
    endtask

    task automatic test_disable_mid_hold();
        mode = 1'b0; dest_en = 4'b1111; out_ready = 4'b1101;
        in_valid = 1'b1; in_data = 8'h41;
        @(posedge clk); #1;
        checks++; if (sel !== 2'd0) $display("FAIL dis_first_sel got %0d exp 0", sel); else passed++;
        in_data = 8'h42;
        @(posedge clk); #1;
        checks++; if (sel !== 2'd1) $display("FAIL dis_hold_sel got %0d exp 1", sel); else passed++;
        checks++; if (out_data !== 8'h42) $display("FAIL dis_hold_data got %h exp 42", out_data); else passed++;
        in_valid = 1'b0; dest_en = 4'b1101;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 4'b0010) $display("FAIL dis_stable_valid[%0d] got %b exp 0010", i, out_valid); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL dis_stable_ready[%0d] got %b exp 0", i, in_ready); else passed++;
        end
        out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h43;
        @(posedge clk); #1;
        checks++; if (sel !== 2'd2) $display("FAIL dis_skip_sel got %0d exp 2", sel); else passed++;
        checks++; if (out_valid !== 4'b0100) $display("FAIL dis_skip_valid got %b exp 0100", out_valid); else passed++;
        checks++; if (out_data !== 8'h43) $display("FAIL dis_skip_data got %h exp 43", out_data); else passed++;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_hold();
        mode = 1'b0; dest_en = 4'b1111; out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'h77;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0100) $display("FAIL rst_hold_valid got %b exp 0100", out_valid); else passed++;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000) $display("FAIL rst_mid_valid got %b exp 0000", out_valid); else passed++;
        checks++; if (sel !== 2'd0) $display("FAIL rst_mid_sel got %0d exp 0", sel); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_mid_ready got %b exp 0", in_ready); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h12;
        @(posedge clk); #1;
        checks++; if (sel !== 2'd0) $display("FAIL rst_after_sel got %0d exp 0", sel); else passed++;
        checks++; if (out_valid !== 4'b0001) $display("FAIL rst_after_valid got %b exp 0001", out_valid); else passed++;
        checks++; if (out_data !== 8'h12) $display("FAIL rst_after_data got %h exp 12", out_data); else passed++;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_no_dest();
        mode = 1'b1; dest_en = 4'b1111; out_ready = 4'b0000;
        in_valid = 1'b1; in_dest = 2'd3; in_data = 8'h5E;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b1000) $display("FAIL nd_hold_valid got %b exp 1000", out_valid); else passed++;
        dest_en = 4'b0000; in_data = 8'h6F; out_ready = 4'b1111;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL nd_ready got %b exp 0", in_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 4'b0000) $display("FAIL nd_complete_valid got %b exp 0000", out_valid); else passed++;
        checks++; if (err_drop !== 1'b0) $display("FAIL nd_err got %b exp 0", err_drop); else passed++;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) $display("FAIL nd_idle_busy got %b exp 0", busy); else passed++;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_burst();
        test_rr_skip();
        test_directed();
        test_backpressure();
        test_disable_mid_hold();
        test_reset_mid_hold();
        test_no_dest();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
